// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared opcodes, FSM encoding and counter sizing for alu_seq
//
// Purpose: constants and types imported by alu_seq and alu_seq_mul.
// Ports:   none (package).
package alu_seq_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_SQU = 4'b0001;
    localparam logic [3:0] OP_NOR = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_MOV = 4'b1111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // clog2(width + 1): bits needed to hold an iteration count of 0..width
    function automatic int iter_cnt_width(input int width);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < (width + 1)) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// rtl/alu_seq_mul.sv - iterative radix-2 shift-add unsigned multiplier
//
// Purpose: computes a*b over WIDTH cycles, one multiplier bit per cycle.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   load         capture a (multiplicand) and b (multiplier), start iterating
//   a, b         WIDTH-bit unsigned operands
//   busy         iterations in progress
//   done         high during the final iteration cycle; product is valid then
//   product      2*WIDTH-bit result, meaningful while done is high
module alu_seq_mul
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = iter_cnt_width(WIDTH);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] hi_next;
    logic [WIDTH-1:0] lo_next;

    // {hi, lo} is the partial product with the unconsumed multiplier bits in
    // the low end of lo; each step adds the multiplicand on lo[0] and shifts
    // the whole pair right, so after WIDTH steps {hi, lo} holds the product.
    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        hi_next = sum[WIDTH:1];
        lo_next = {sum[0], lo[WIDTH-1:1]};
    end

    // The product is taken from the next-state value so the owner can
    // register it on the same edge that retires the final iteration.
    assign done    = busy && (cnt == CW'(WIDTH - 1));
    assign product = {hi_next, lo_next};

    always_ff @(posedge clk) begin
        if (reset) begin
            busy  <= 1'b0;
            cnt   <= '0;
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
        end else if (load) begin
            busy  <= 1'b1;
            cnt   <= '0;
            mcand <= a;
            hi    <= '0;
            lo    <= b;
        end else if (busy) begin
            hi <= hi_next;
            lo <= lo_next;
            if (cnt == CW'(WIDTH - 1)) begin
                busy <= 1'b0;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU: single-cycle logic/arith ops plus iterative MUL/SQU
//
// Purpose: accepts one operation per start when idle; single-cycle ops finish
//          on the next cycle, MUL/SQU run WIDTH cycles on alu_seq_mul.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   start          request, sampled only while busy=0
//   ALUOperation   4-bit opcode, sampled with start
//   A, B           WIDTH-bit operands, sampled with start
//   busy           multi-cycle operation in progress
//   done           one-cycle pulse, result outputs updated
//   ALUResult      result (low product half for MUL/SQU)
//   ResultHi       high product half for MUL/SQU, else 0
//   Zero           ALUResult == 0
//   Overflow       signed overflow for ADD/SUB, else 0
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       ALUOperation,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ALUResult,
    output logic [WIDTH-1:0] ResultHi,
    output logic             Zero,
    output logic             Overflow
);

    state_t state;
    state_t state_next;

    logic                 accept;
    logic                 is_mul;
    logic                 mul_load;
    logic                 mul_busy;
    logic                 mul_done;
    logic [WIDTH-1:0]     mul_b;
    logic [2*WIDTH-1:0]   product;

    logic [WIDTH-1:0]     sum;
    logic [WIDTH-1:0]     diff;
    logic [WIDTH-1:0]     sc_res;
    logic                 sc_ovf;

    assign is_mul = (ALUOperation == OP_MUL) || (ALUOperation == OP_SQU);
    // Squaring reuses the multiplier with the multiplier operand tied to A.
    assign mul_b  = (ALUOperation == OP_SQU) ? A : B;

    assign busy = (state == ST_RUN);
    assign Zero = (ALUResult == '0);

    alu_seq_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .load    (mul_load),
        .a       (A),
        .b       (mul_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (product)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        mul_load   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !mul_busy) begin
                    accept = 1'b1;
                    if (is_mul) begin
                        mul_load   = 1'b1;
                        state_next = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (mul_done) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Single-cycle datapath; unlisted opcodes fall through to a zero result.
    always_comb begin
        sum    = A + B;
        diff   = A - B;
        sc_res = '0;
        sc_ovf = 1'b0;
        case (ALUOperation)
            OP_AND: sc_res = A & B;
            OP_NOR: sc_res = ~(A | B);
            OP_ADD: begin
                sc_res = sum;
                sc_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = diff;
                sc_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SLT: sc_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_MOV: sc_res = {{(WIDTH-1){1'b0}}, (A == B)};
            default: begin
                sc_res = '0;
                sc_ovf = 1'b0;
            end
        endcase
    end

    // Result registers only move on a completion, so they hold through RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            done      <= 1'b0;
            ALUResult <= '0;
            ResultHi  <= '0;
            Overflow  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept && !is_mul) begin
                done      <= 1'b1;
                ALUResult <= sc_res;
                ResultHi  <= '0;
                Overflow  <= sc_ovf;
            end else if (mul_done) begin
                done      <= 1'b1;
                ALUResult <= product[WIDTH-1:0];
                ResultHi  <= product[2*WIDTH-1:WIDTH];
                Overflow  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq (WIDTH=32 randomized, WIDTH=8 directed)
module tb_alu_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [3:0]   op = 4'h0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, zero, ovf;
    logic [W-1:0] res, hi;

    logic         reset8 = 1'b1;
    logic         start8 = 1'b0;
    logic [3:0]   op8 = 4'h0;
    logic [7:0]   a8 = '0;
    logic [7:0]   b8 = '0;
    logic         busy8, done8, zero8, ovf8;
    logic [7:0]   res8, hi8;
    logic         fin8 = 1'b0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .ALUOperation(op), .A(a), .B(b),
        .busy(busy), .done(done), .ALUResult(res), .ResultHi(hi), .Zero(zero), .Overflow(ovf)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset8), .start(start8), .ALUOperation(op8), .A(a8), .B(b8),
        .busy(busy8), .done(done8), .ALUResult(res8), .ResultHi(hi8), .Zero(zero8), .Overflow(ovf8)
    );

    typedef struct {
        int           cyc;
        logic [3:0]   op;
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         zero;
        logic         ovf;
    } exp_t;

    exp_t         q[$];
    int           cyc = 0;
    int           busy_from = 1;
    int           busy_until = 0;
    logic [W-1:0] last_res = '0;
    logic [W-1:0] last_hi = '0;
    logic         last_zero = 1'b1;
    logic         last_ovf = 1'b0;
    int           n_pass = 0;
    int           n_total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        else n_pass++;
    endtask

    // Reference: results straight from the arithmetic definitions.
    function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t   e;
        longint sx, sy, r, lim;
        logic [2*W-1:0] p;
        sx  = $signed(x);
        sy  = $signed(y);
        lim = longint'(1) <<< (W - 1);
        e.cyc = 0; e.op = o; e.res = '0; e.hi = '0; e.ovf = 1'b0;
        case (o)
            4'h0: e.res = x & y;
            4'h2: e.res = ~(x | y);
            4'h3: begin r = sx + sy; e.res = W'(r); e.ovf = (r >= lim) || (r < -lim); end
            4'h6: begin r = sx - sy; e.res = W'(r); e.ovf = (r >= lim) || (r < -lim); end
            4'h7: e.res = (sx < sy) ? 1 : 0;
            4'hF: e.res = (x == y) ? 1 : 0;
            4'h4: begin p = (2*W)'(x) * (2*W)'(y); e.res = p[W-1:0]; e.hi = p[2*W-1:W]; end
            4'h1: begin p = (2*W)'(x) * (2*W)'(x); e.res = p[W-1:0]; e.hi = p[2*W-1:W]; end
            default: e.res = '0;
        endcase
        e.zero = (e.res == '0);
        return e;
    endfunction

    function automatic logic [W-1:0] rand_val();
        case ($urandom_range(0, 6))
            0: return '0;
            1: return 1;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Called at a falling edge; drives one cycle of start and, if the bench
    // expects the request to be accepted, queues its expected completion.
    task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        op = o; a = x; b = y; start = 1'b1;
        if (cyc > busy_until) begin
            e = model(o, x, y);
            if (o == 4'h4 || o == 4'h1) begin
                e.cyc      = cyc + W + 1;
                busy_from  = cyc + 1;
                busy_until = cyc + W;
            end else begin
                e.cyc = cyc + 1;
            end
            q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!reset) begin
                chk("busy", busy, (cyc >= busy_from) && (cyc <= busy_until));
                if (done) begin
                    if (q.size() == 0 || q[0].cyc != cyc) begin
                        n_total++;
                        $display("FAIL done_unexpected: done=1 at cycle %0d, want done=0", cyc);
                    end else begin
                        e = q.pop_front();
                        chk($sformatf("ALUResult op=%h", e.op), res, e.res);
                        chk($sformatf("ResultHi op=%h", e.op), hi, e.hi);
                        chk($sformatf("Zero op=%h", e.op), zero, e.zero);
                        chk($sformatf("Overflow op=%h", e.op), ovf, e.ovf);
                        last_res = e.res; last_hi = e.hi; last_zero = e.zero; last_ovf = e.ovf;
                    end
                end else begin
                    if (q.size() > 0 && q[0].cyc < cyc) begin
                        n_total++;
                        $display("FAIL done_missing: done=0 at cycle %0d, want done=1 at cycle %0d", cyc, q[0].cyc);
                        e = q.pop_front();
                    end
                    chk("hold_ALUResult", res, last_res);
                    chk("hold_ResultHi", hi, last_hi);
                    chk("hold_Zero", zero, last_zero);
                    chk("hold_Overflow", ovf, last_ovf);
                end
            end
        end
    end

    initial begin : drive8
        int k;
        repeat (3) @(negedge clk);
        reset8 = 1'b0;
        op8 = 4'b0001; a8 = 8'hFF; b8 = 8'($urandom); start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        k = 1;
        while (!done8 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("w8_squ_latency", k, 9);
        chk("w8_squ_ALUResult", res8, 8'h01);
        chk("w8_squ_ResultHi", hi8, 8'hFE);
        chk("w8_squ_Zero", zero8, 1'b0);
        op8 = 4'b1010; a8 = 8'($urandom); b8 = 8'($urandom); start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        chk("w8_undef_done", done8, 1'b1);
        chk("w8_undef_ALUResult", res8, 8'h00);
        chk("w8_undef_ResultHi", hi8, 8'h00);
        chk("w8_undef_Zero", zero8, 1'b1);
        chk("w8_undef_Overflow", ovf8, 1'b0);
        fin8 = 1'b1;
    end

    initial begin : main
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ALUResult", res, '0);
        chk("rst_ResultHi", hi, '0);
        chk("rst_Zero", zero, 1'b1);
        chk("rst_Overflow", ovf, 1'b0);
        @(negedge clk);

        issue(4'h3, 32'h7FFF_FFFF, 32'h0000_0001);
        issue(4'h6, 32'd5, 32'd5);
        issue(4'h7, 32'hFFFF_FFFF, 32'd1);
        issue(4'h4, 32'hFFFF_FFFF, 32'd2);
        while (cyc <= busy_until) begin
            if (cyc == busy_from + 5) issue(4'h3, 32'd100, 32'd200);
            else @(negedge clk);
        end
        issue(4'h3, 32'd3, 32'd4);
        issue(4'hA, rand_val(), rand_val());

        // Abort a multiply partway through.
        issue(4'h4, rand_val(), rand_val());
        repeat (9) @(negedge clk);
        reset = 1'b1;
        q.delete();
        busy_from = 1; busy_until = 0;
        last_res = '0; last_hi = '0; last_zero = 1'b1; last_ovf = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_ALUResult", res, '0);
        chk("abort_Zero", zero, 1'b1);
        repeat (40) @(negedge clk);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            else issue(4'($urandom_range(0, 15)), rand_val(), rand_val());
        end

        for (int i = 0; i < 60 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            n_total++;
            $display("FAIL drain: %0d completions outstanding, want 0", q.size());
        end
        for (int i = 0; i < 100 && !fin8; i++) @(negedge clk);
        if (!fin8) begin
            n_total++;
            $display("FAIL w8_timeout: width-8 sequence incomplete");
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 32: operand/result width, legal range 4..64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 start  input  1  request; sampled only when busy=0.
REQ-005 ALUOperation  input  4  opcode, sampled with start.
REQ-006 A  input  WIDTH  operand A, sampled with start.
REQ-007 B  input  WIDTH  operand B, sampled with start.
REQ-008 busy  output  1  high while multi-cycle op in progress.
REQ-009 done  output  1  one-cycle pulse: result outputs valid.
REQ-010 ALUResult  output  WIDTH  result (low half for MUL/SQU).
REQ-011 ResultHi  output  WIDTH  upper product half for MUL/SQU; 0 otherwise.
REQ-012 Zero  output  1  ALUResult==0.
REQ-013 Overflow  output  1  signed overflow for ADD/SUB; 0 otherwise.

Function
REQ-014 Opcodes: AND 0000, SQU 0001, NOR 0010, ADD 0011, MUL 0100, SUB 0110, SLT 0111, MOV 1111.
REQ-015 AND: A&B; NOR: ~(A|B); ADD: A+B mod 2^WIDTH; SUB: A-B mod 2^WIDTH; MOV: (A==B) zero-extended; SLT: (signed A < signed B) zero-extended.
REQ-016 MUL: unsigned A*B, 2*WIDTH bits, {ResultHi,ALUResult}; SQU: unsigned A*A, same split.
REQ-017 Undefined opcode: ALUResult=0, ResultHi=0, Zero=1, Overflow=0, latency as single-cycle op.
REQ-018 FSM states IDLE, RUN; IDLE->RUN on accepted MUL/SQU; RUN->IDLE after WIDTH iterations; reset->IDLE.
REQ-019 Accept: start=1 and busy=0 at a rising edge; operands/opcode captured into internal registers.
REQ-020 Single-cycle ops: outputs registered at accepting edge; done=1 the following cycle; state stays IDLE.
REQ-021 Back-to-back single-cycle ops accepted every cycle; done high each cycle with respective result.
REQ-022 MUL/SQU: radix-2 shift-add, one multiplier bit per cycle; busy=1 for exactly WIDTH cycles after accept; done=1 in cycle WIDTH+1 after accepting edge.
REQ-023 busy=0 in the done cycle; start in that cycle is accepted.
REQ-024 start while busy=1 ignored; no effect on operation or outputs.
REQ-025 ALUResult, ResultHi, Zero, Overflow hold last completed values until next done; never change mid-RUN.
REQ-026 Overflow on ADD: operand signs equal and result sign differs; on SUB: operand signs differ and result sign differs from A.
REQ-027 Zero evaluated on registered ALUResult only (ResultHi ignored).

Reset
REQ-028 reset=1 at an edge: state IDLE, busy=0, done=0, ALUResult=0, ResultHi=0, Zero=1, Overflow=0, iteration counter 0.
REQ-029 Reset during RUN aborts operation; no done generated for it.
REQ-030 start ignored while reset=1; reset overrides all other inputs.

Structure
REQ-031 Package alu_seq_pkg holds opcode constants, FSM state encoding, and iteration-counter width function clog2(WIDTH+1).
REQ-032 Sub-module alu_seq_mul: iterative shift-add multiplier with load, busy, done, 2*WIDTH product; shared by MUL and SQU (SQU loads B=A).
REQ-033 Single-cycle datapath and flag logic in alu_seq top; no latches; one clock domain.

Verification
REQ-034 WIDTH=32, ADD A=0x7FFFFFFF B=0x00000001 -> next cycle done=1, ALUResult=0x80000000, Overflow=1, Zero=0.
REQ-035 SUB A=5 B=5, then SLT A=0xFFFFFFFF B=1 on consecutive cycles -> done two consecutive cycles: 0/Zero=1, then 1/Zero=0.
REQ-036 MUL A=0xFFFFFFFF B=2 -> busy high 32 cycles, done at cycle 33, ALUResult=0xFFFFFFFE, ResultHi=0x00000001.
REQ-037 start ADD during MUL busy -> ignored; start ADD 3+4 in MUL done cycle -> next cycle done, ALUResult=7.
REQ-038 reset asserted 10 cycles into MUL -> next cycle busy=0, done=0, ALUResult=0, Zero=1; no done in following 40 cycles.
REQ-039 WIDTH=8, SQU A=0xFF -> done at cycle 9, ALUResult=0x01, ResultHi=0xFE; opcode 1010 -> result 0, Zero=1.
